jtag_debug_cmd_queue: RTL and testbench
=======================================

// Module: jtag_debug_cmd_queue
// PURPOSE
//  Parametrised sysclk-side command receiver for the CPU JTAG debug module.
//  Synchronises the virtual-JTAG update-DR/update-IR strobes from the tck domain into clk.
//  Queues each captured {IR, shift-register} pair in a DEPTH-entry FIFO and releases
//  commands to the CPU debug logic over a valid/ready handshake.
//  Emits per-instruction take_action / take_no_action pulses; sits between the tck block and OCI logic.
// PARAMETERS
//  IR_W         2   virtual JTAG instruction width; 2**IR_W one-hot action lines
//  DR_W         38  shift-register / jdo width
//  DEPTH        4   command FIFO entries, power of two, >=2
//  SYNC_STAGES  2   synchroniser flops on vs_udr / vs_uir, >=2
//  ACTION_BIT   34  sr bit selecting take_action (1) vs take_no_action (0)
//  FLUSH_ON_UIR 1   1: a synchronised update-IR discards all queued commands
// PORTS
//  clk            in   1            system clock
//  reset_n        in   1            asynchronous active-low reset
//  ir_in          in   IR_W         tck-domain IR, stable across update-DR
//  sr             in   DR_W         tck-domain shift register, stable across update-DR
//  vs_udr         in   1            async update-DR level from tck domain
//  vs_uir         in   1            async update-IR level from tck domain
//  cmd_ready      in   1            CPU debug logic accepts head command
//  clr_ovf        in   1            clears overflow sticky
//  cmd_valid      out  1            FIFO non-empty
//  cmd_ir         out  IR_W         IR of head command
//  jdo            out  DR_W         data of last popped command, held until next pop
//  take_action    out  2**IR_W      one-hot pulse, index = popped IR, when data[ACTION_BIT]=1
//  take_no_action out  2**IR_W      one-hot pulse, index = popped IR, when data[ACTION_BIT]=0
//  ir_update      out  1            one-cycle pulse per synchronised update-IR
//  level          out  clog2(DEPTH)+1  queued entry count
//  overflow       out  1            sticky: a command was dropped
//  parity_err     out  1            sticky; present only with JTAG_CMD_PARITY_EN
// BEHAVIOUR
//  - Reset: every output 0, FIFO empty, pointers 0, synchroniser chains 0.
//  - Sync: vs_udr and vs_uir each pass through SYNC_STAGES flops plus one edge-detect flop.
//    A rising edge of the synchronised level gives a single-cycle udr_p / uir_p; falling edges are ignored.
//  - Capture: on udr_p, {ir_in, sr} is pushed.
//    Latency from the vs_udr rise to cmd_valid=1 is SYNC_STAGES+2 clk cycles; there is no empty bypass.
//  - Pop: occurs when cmd_valid && cmd_ready.
//    On the following edge: jdo <= head data, and the pointer advances.
//    Exactly one of take_action[ir] / take_no_action[ir] pulses high for one cycle.
//    Pulses and the new jdo are visible in the same cycle.
//  - cmd_ready with cmd_valid=0: no effect, no pulses.
//  - Full: a push with level==DEPTH and no pop in the same cycle is dropped and sets overflow.
//    A push while full with a pop in the same cycle is accepted, and level stays DEPTH.
//  - Empty: level=0, cmd_valid=0, cmd_ir=0.
//  - Pointer wrap: modulo DEPTH; level is computed from pointers with an extra wrap bit.
//  - overflow: stays 1 until clr_ovf=1 on a cycle with no new drop.
//    A new drop in the same cycle as clr_ovf wins, and overflow stays 1.
//  - uir_p: ir_update pulses for one cycle, the cycle after uir_p.
//    If FLUSH_ON_UIR=1, the FIFO empties on that edge and any same-cycle pop is cancelled (no pulses).
//    A same-cycle udr_p is applied after the flush, so level becomes 1.
//  - The reset_n assertion mid-transfer clears the queue immediately.
//    The synchronisers restart from 0, so a vs_udr level held high through reset produces no push after reset.
// CONFIGURATION
//  JTAG_CMD_PARITY_EN defined:
//    - sr[DR_W-1] is an odd-parity bit over sr[DR_W-2:0] and ir_in.
//    - A failing command is not pushed and sets parity_err (sticky, cleared by clr_ovf).
//  JTAG_CMD_PARITY_EN undefined:
//    - No check is made; sr[DR_W-1] is ordinary data.
//    - The parity_err port is absent.
// TESTING
//  1. vs_udr 0->1, ir_in=2, sr[34]=1, cmd_ready=1
//     -> cmd_valid at cycle 4, take_action=4'b0100 for one cycle, jdo=sr, level back to 0.
//  2. Five pushes with cmd_ready=0, DEPTH=4
//     -> level=4, overflow=1, then four pops return the first four sr values in order.
//  3. Full queue, push and pop in the same cycle -> level stays 4, overflow stays 0, and the new entry is last out.
//  4. Two queued commands, then vs_uir rise with a same-cycle udr_p
//     -> ir_update pulse, level=1, and only the new command pops.
//  5. sr[34]=0 with ir_in=1 -> take_no_action=4'b0010, take_action=0.
//  6. reset_n low with level=3 -> all outputs 0 at once; with JTAG_CMD_PARITY_EN, bad parity -> level 0, parity_err=1.

Source files
------------

// File: rtl/jtag_debug_cmd_queue.sv
// Clock-domain receiver for virtual-JTAG update-DR/IR strobes; queues {IR, DR} commands for the CPU debug logic.
// Optional odd-parity screening of captured commands is enabled by defining JTAG_CMD_PARITY_EN.
module jtag_debug_cmd_queue #(
  parameter int IR_W         = 2,
  parameter int DR_W         = 38,
  parameter int DEPTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int ACTION_BIT   = 34,
  parameter int FLUSH_ON_UIR = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [DR_W-1:0]            sr,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic                       cmd_ready,
  input  logic                       clr_ovf,
  output logic                       cmd_valid,
  output logic [IR_W-1:0]            cmd_ir,
  output logic [DR_W-1:0]            jdo,
  output logic [(1<<IR_W)-1:0]       take_action,
  output logic [(1<<IR_W)-1:0]       take_no_action,
  output logic                       ir_update,
  output logic [$clog2(DEPTH):0]     level,
`ifdef JTAG_CMD_PARITY_EN
  output logic                       parity_err,
`endif
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = IR_W + DR_W;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync, settle;
  logic                   udr_seen, uir_seen, udr_p, uir_p;

  // The seen flops start at 1 and only track the synchronised level once the chains
  // have refilled, so a strobe held high across reset never looks like a new edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      settle   <= '0;
      udr_seen <= 1'b1;
      uir_seen <= 1'b1;
      udr_p    <= 1'b0;
      uir_p    <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      settle   <= {settle[SYNC_STAGES-2:0], 1'b1};
      udr_p    <= settle[SYNC_STAGES-1] & udr_sync[SYNC_STAGES-1] & ~udr_seen;
      uir_p    <= settle[SYNC_STAGES-1] & uir_sync[SYNC_STAGES-1] & ~uir_seen;
      udr_seen <= settle[SYNC_STAGES-1] ? udr_sync[SYNC_STAGES-1] : 1'b1;
      uir_seen <= settle[SYNC_STAGES-1] ? uir_sync[SYNC_STAGES-1] : 1'b1;
    end
  end

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          cmd_ok, flush, pop, push_req, drop, push;

`ifdef JTAG_CMD_PARITY_EN
  assign cmd_ok = ^{ir_in, sr};
`else
  assign cmd_ok = 1'b1;
`endif

  assign level     = wr_ptr - rd_ptr;
  assign cmd_valid = (wr_ptr != rd_ptr);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign cmd_ir    = cmd_valid ? head[EW-1:DR_W] : '0;

  // A flush empties the queue first, so a coincident capture always fits.
  always_comb begin
    flush    = uir_p && (FLUSH_ON_UIR != 0);
    pop      = cmd_valid && cmd_ready && !flush;
    push_req = udr_p && cmd_ok;
    drop     = push_req && !flush && (level == FULL_LVL) && !pop;
    push     = push_req && !drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      ir_update      <= uir_p;
      take_action    <= '0;
      take_no_action <= '0;
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        jdo    <= head[DR_W-1:0];
        if (head[ACTION_BIT]) take_action[head[EW-1:DR_W]]    <= 1'b1;
        else                  take_no_action[head[EW-1:DR_W]] <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ir_in, sr};
  end

`ifdef JTAG_CMD_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                parity_err <= 1'b0;
    else if (udr_p && !cmd_ok)   parity_err <= 1'b1;
    else if (clr_ovf)            parity_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
// Bench for jtag_debug_cmd_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_jtag_debug_cmd_queue;
  localparam int IR_W  = 2;
  localparam int DR_W  = 38;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [IR_W-1:0]   ir_in = '0;
  logic [DR_W-1:0]   sr = '0;
  logic              vs_udr = 1'b0, vs_uir = 1'b0, cmd_ready = 1'b0, clr_ovf = 1'b0;
  logic              cmd_valid, ir_update, overflow;
  logic [IR_W-1:0]   cmd_ir;
  logic [DR_W-1:0]   jdo;
  logic [3:0]        take_action, take_no_action;
  logic [2:0]        level;
`ifdef JTAG_CMD_PARITY_EN
  logic              parity_err;
`endif

  jtag_debug_cmd_queue dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .cmd_ready(cmd_ready), .clr_ovf(clr_ovf), .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action), .ir_update(ir_update), .level(level),
`ifdef JTAG_CMD_PARITY_EN
    .parity_err(parity_err),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a queue of {ir, sr} commands plus the expected registered outputs.
  logic [IR_W+DR_W-1:0] mq[$];
  logic [DR_W-1:0]      m_jdo;
  logic [3:0]           m_ta, m_tna;
  logic                 m_iru, m_ovf, m_perr;
  logic [7:0]           udr_h, uir_h;
  bit                   rnd_mode = 0;
  int                   ready_pct = 50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DR_W-1:0] rnd38();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DR_W-1:0];
  endfunction

  function automatic logic [DR_W-1:0] fixp(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] d);
    logic [DR_W-1:0] o;
    o = d;
`ifdef JTAG_CMD_PARITY_EN
    o[DR_W-1] = ~(^{ir, d[DR_W-2:0]});
`endif
    return o;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_jdo = '0; m_ta = '0; m_tna = '0; m_iru = 0; m_ovf = 0; m_perr = 0;
    udr_h = {8{vs_udr}};
    uir_h = {8{vs_uir}};
  endtask

  // One clock: predict from the rules (capture 4 edges after a strobe rise), advance, then compare.
  task automatic cycle();
    logic push, uirp, ok, drop;
    logic [IR_W+DR_W-1:0] e;
    if (rnd_mode) begin
      cmd_ready = ($urandom_range(0, 99) < ready_pct);
      clr_ovf   = ($urandom_range(0, 15) == 0);
    end
    if (reset_n) begin
      udr_h = {udr_h[6:0], vs_udr};
      uir_h = {uir_h[6:0], vs_uir};
    end
    push = reset_n && udr_h[3] && !udr_h[4];
    uirp = reset_n && uir_h[3] && !uir_h[4];
    ok = 1'b1;
`ifdef JTAG_CMD_PARITY_EN
    ok = ^{ir_in, sr};
    if (reset_n) begin
      if (push && !ok) m_perr = 1;
      else if (clr_ovf) m_perr = 0;
    end
`endif
    m_ta = '0; m_tna = '0; m_iru = uirp; drop = 0;
    if (reset_n) begin
      if (uirp) mq.delete();
      else if (mq.size() > 0 && cmd_ready) begin
        e = mq.pop_front();
        m_jdo = e[DR_W-1:0];
        if (e[34]) m_ta[e[IR_W+DR_W-1:DR_W]] = 1'b1;
        else       m_tna[e[IR_W+DR_W-1:DR_W]] = 1'b1;
      end
      if (push && ok) begin
        if (mq.size() == DEPTH) drop = 1;
        else mq.push_back({ir_in, sr});
      end
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
    @(posedge clk);
    #1;
    chk("level", 64'(level), 64'(mq.size()));
    chk("cmd_valid", 64'(cmd_valid), 64'(mq.size() != 0));
    chk("cmd_ir", 64'(cmd_ir), (mq.size() != 0) ? 64'(mq[0][IR_W+DR_W-1:DR_W]) : 64'd0);
    chk("jdo", 64'(jdo), 64'(m_jdo));
    chk("take_action", 64'(take_action), 64'(m_ta));
    chk("take_no_action", 64'(take_no_action), 64'(m_tna));
    chk("ir_update", 64'(ir_update), 64'(m_iru));
    chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef JTAG_CMD_PARITY_EN
    chk("parity_err", 64'(parity_err), 64'(m_perr));
`endif
  endtask

  task automatic send(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] d,
                      input int hi, input int lo, input logic with_uir);
    ir_in  = ir;
    sr     = fixp(ir, d);
    vs_udr = 1'b1;
    vs_uir = with_uir;
    repeat (hi) cycle();
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    repeat (lo) cycle();
  endtask

  logic [DR_W-1:0] saved [5];
  logic [DR_W-1:0] t3;
  logic [DR_W-1:0] bad;

  initial begin
    model_reset();
    repeat (3) cycle();
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_valid", 64'(cmd_valid), 64'd0);
    reset_n = 1'b1;
    repeat (4) cycle();

    // Single command, immediately accepted.
    ir_in = 2'd2; sr = fixp(2'd2, rnd38() | (38'd1 << 34)); cmd_ready = 1'b1; vs_udr = 1'b1;
    repeat (3) cycle();
    chk("t1_valid_c3", 64'(cmd_valid), 64'd0);
    cycle();
    chk("t1_valid_c4", 64'(cmd_valid), 64'd1);
    cycle();
    chk("t1_take_action", 64'(take_action), 64'b0100);
    chk("t1_jdo", 64'(jdo), 64'(sr));
    chk("t1_level", 64'(level), 64'd0);
    vs_udr = 1'b0;
    cycle();
    chk("t1_pulse_end", 64'(take_action), 64'd0);
    repeat (3) cycle();

    // Overflow: five pushes into four entries, then drain in order.
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(IR_W'(i), rnd38(), 4, 3, 1'b0);
      saved[i] = sr;
    end
    chk("t2_level_full", 64'(level), 64'd4);
    chk("t2_overflow", 64'(overflow), 64'd1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_pop_order", 64'(jdo), 64'(saved[i]));
    end
    cmd_ready = 1'b0; clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    chk("t2_ovf_cleared", 64'(overflow), 64'd0);

    // Push and pop in the same cycle while full.
    for (int i = 0; i < 4; i++) send(IR_W'(i), rnd38(), 4, 3, 1'b0);
    ir_in = 2'd3; sr = fixp(2'd3, rnd38()); vs_udr = 1'b1; t3 = sr;
    repeat (3) cycle();
    cmd_ready = 1'b1;
    cycle();
    cmd_ready = 1'b0;
    chk("t3_level", 64'(level), 64'd4);
    chk("t3_overflow", 64'(overflow), 64'd0);
    vs_udr = 1'b0;
    cmd_ready = 1'b1;
    repeat (4) cycle();
    chk("t3_last_out", 64'(jdo), 64'(t3));
    chk("t3_empty", 64'(level), 64'd0);
    cmd_ready = 1'b0;
    repeat (2) cycle();

    // Update-IR flush with a coincident capture.
    send(2'd0, rnd38(), 4, 3, 1'b0);
    send(2'd3, rnd38(), 4, 3, 1'b0);
    ir_in = 2'd1; sr = fixp(2'd1, rnd38()); vs_udr = 1'b1; vs_uir = 1'b1; t3 = sr;
    repeat (3) cycle();
    cmd_ready = 1'b1;
    cycle();
    chk("t4_ir_update", 64'(ir_update), 64'd1);
    chk("t4_level", 64'(level), 64'd1);
    chk("t4_no_pulse", 64'(take_action | take_no_action), 64'd0);
    cycle();
    chk("t4_new_cmd", 64'(jdo), 64'(t3));
    chk("t4_iru_end", 64'(ir_update), 64'd0);
    vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0;
    repeat (3) cycle();

    // No-action command.
    cmd_ready = 1'b1; ir_in = 2'd1; sr = fixp(2'd1, rnd38() & ~(38'd1 << 34)); vs_udr = 1'b1;
    repeat (5) cycle();
    chk("t5_take_no_action", 64'(take_no_action), 64'b0010);
    chk("t5_take_action", 64'(take_action), 64'd0);
    vs_udr = 1'b0;
    repeat (3) cycle();

    // Asynchronous reset with three queued entries and vs_udr held high through it.
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(IR_W'(i), rnd38() | (38'd1 << 34), 4, 3, 1'b0);
    chk("t6_level3", 64'(level), 64'd3);
    vs_udr = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_level", 64'(level), 64'd0);
    chk("t6_rst_valid", 64'(cmd_valid), 64'd0);
    chk("t6_rst_jdo", 64'(jdo), 64'd0);
    chk("t6_rst_pulses", 64'(take_action | take_no_action), 64'd0);
    chk("t6_rst_flags", 64'({ir_update, overflow, cmd_ir}), 64'd0);
    model_reset();
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (10) cycle();
    chk("t6_no_push_after_reset", 64'(level), 64'd0);
    vs_udr = 1'b0;
    repeat (3) cycle();

`ifdef JTAG_CMD_PARITY_EN
    ir_in = 2'd0; bad = fixp(2'd0, rnd38()); bad[DR_W-1] = ~bad[DR_W-1]; sr = bad; vs_udr = 1'b1;
    repeat (5) cycle();
    chk("t6_parity_level", 64'(level), 64'd0);
    chk("t6_parity_err", 64'(parity_err), 64'd1);
    vs_udr = 1'b0; clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    chk("t6_parity_clr", 64'(parity_err), 64'd0);
    repeat (2) cycle();
`endif

    // Randomized traffic against the model.
    rnd_mode = 1;
    for (int k = 0; k < 150; k++) begin
      if (k % 25 == 0) begin
        case ($urandom_range(0, 2))
          0: ready_pct = 5;
          1: ready_pct = 30;
          default: ready_pct = 90;
        endcase
      end
      send(IR_W'($urandom_range(0, 3)), rnd38(), $urandom_range(4, 6), $urandom_range(1, 4),
           ($urandom_range(0, 9) == 0));
    end
    rnd_mode = 0;
    clr_ovf = 1'b0;
    cmd_ready = 1'b1;
    repeat (8) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
